// File: rtl/cpu_press_pkg.sv
// Shared types and constants for the CPU press generator.
package cpu_press_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_e;

    localparam int unsigned LFSR_W        = 10;
    localparam int unsigned TAP_HI        = 9;
    localparam int unsigned TAP_LO        = 6;
    localparam int unsigned CNT_W         = 4;
    localparam int unsigned DIFF_W        = 9;
    localparam int unsigned PRESS_CNT_W   = 8;
    localparam int unsigned PRESS_CNT_MAX = 255;

endpackage

// File: rtl/cpu_press_gen_if.sv
// Press interface between the game tick domain and the CPU press generator.
interface cpu_press_gen_if;

    logic                                    tick;
    logic                                    enable;
    logic [cpu_press_pkg::DIFF_W-1:0]        difficulty;
    logic                                    pressed;
    logic                                    busy;
    logic [cpu_press_pkg::PRESS_CNT_W-1:0]   press_count;

    modport master (
        input  tick, enable, difficulty,
        output pressed, busy, press_count
    );

    modport slave (
        output tick, enable, difficulty,
        input  pressed, busy, press_count
    );

endinterface

// File: rtl/lfsr10.sv
// 10-bit XNOR Fibonacci LFSR (x^10 + x^7 + 1), advancing on tick, reloading seed on Reset.
module lfsr10
    import cpu_press_pkg::*;
(
    input  logic              clock,
    input  logic              Reset,
    input  logic              tick,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] value
);

    logic [LFSR_W-1:0] value_q;

    // XNOR feedback makes all-ones the lockup state, so an all-zero seed is legal.
    always_ff @(posedge clock) begin
        if (Reset) begin
            value_q <= seed;
        end else if (tick) begin
            value_q <= {value_q[LFSR_W-2:0], ~(value_q[TAP_HI] ^ value_q[TAP_LO])};
        end
    end

    assign value = value_q;

endmodule

// File: rtl/cpu_press_gen.sv
// Computer-opponent press generator: random press/hold/gap timing on the raw pressed level.
module cpu_press_gen
    import cpu_press_pkg::*;
#(
    parameter int unsigned       HOLD_TICKS = 2,
    parameter int unsigned       GAP_TICKS  = 1,
    parameter logic [LFSR_W-1:0] SEED       = 10'h000
) (
    input  logic             clock,
    input  logic             Reset,
    cpu_press_gen_if.master  bus
);

    state_e                 state_q;
    logic [CNT_W-1:0]       hold_cnt_q;
    logic [CNT_W-1:0]       gap_cnt_q;
    logic                   pressed_q;
    logic                   busy_q;
    logic [PRESS_CNT_W-1:0] press_cnt_q;

    logic [LFSR_W-1:0]      lfsr_c;
    logic [DIFF_W:0]        sum_c;
    logic                   fire_c;
    logic                   unused_lfsr_msb_c;

    lfsr10 u_lfsr (
        .clock (clock),
        .Reset (Reset),
        .tick  (bus.tick),
        .seed  (SEED),
        .value (lfsr_c)
    );

    // Fire when lfsr[8:0] + difficulty carries out of 9 bits; uses the pre-advance LFSR value.
    assign sum_c             = {1'b0, lfsr_c[DIFF_W-1:0]} + {1'b0, bus.difficulty};
    assign fire_c            = sum_c[DIFF_W];
    assign unused_lfsr_msb_c = lfsr_c[LFSR_W-1];

    always_ff @(posedge clock) begin
        if (Reset) begin
            state_q     <= IDLE;
            hold_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            pressed_q   <= 1'b0;
            busy_q      <= 1'b0;
            press_cnt_q <= '0;
        end else if (!bus.enable) begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            gap_cnt_q  <= '0;
            pressed_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else if (bus.tick) begin
            case (state_q)
                IDLE: begin
                    if (fire_c) begin
                        state_q    <= HOLD;
                        hold_cnt_q <= CNT_W'(HOLD_TICKS - 1);
                        pressed_q  <= 1'b1;
                        busy_q     <= 1'b1;
                        if (press_cnt_q != PRESS_CNT_W'(PRESS_CNT_MAX)) begin
                            press_cnt_q <= press_cnt_q + PRESS_CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (hold_cnt_q == '0) begin
                        state_q   <= GAP;
                        gap_cnt_q <= CNT_W'(GAP_TICKS - 1);
                        pressed_q <= 1'b0;
                    end else begin
                        hold_cnt_q <= hold_cnt_q - CNT_W'(1);
                    end
                end
                GAP: begin
                    if (gap_cnt_q == '0) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    hold_cnt_q <= '0;
                    gap_cnt_q  <= '0;
                    pressed_q  <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pressed     = pressed_q;
    assign bus.busy        = busy_q;
    assign bus.press_count = press_cnt_q;

endmodule

// File: tb/tb_cpu_press_gen.sv
// Randomized self-checking bench for cpu_press_gen against a tick-budget reference model.
module tb_cpu_press_gen;

    logic clock = 1'b0;
    logic Reset;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clock = ~clock;

    cpu_press_gen_if ia ();
    cpu_press_gen_if ib ();

    cpu_press_gen u_a (
        .clock (clock),
        .Reset (Reset),
        .bus   (ia)
    );

    cpu_press_gen #(
        .HOLD_TICKS (3),
        .GAP_TICKS  (2),
        .SEED       (10'h000)
    ) u_b (
        .clock (clock),
        .Reset (Reset),
        .bus   (ib)
    );

    // Reference model: a press is a budget of HOLD+GAP ticks; pressed while budget exceeds GAP.
    int m_hold [2] = '{2, 3};
    int m_gap  [2] = '{1, 2};
    int m_lfsr [2];
    int m_left [2];
    int m_cnt  [2];
    int m_raw  [2];

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, got, exp);
        end
    endtask

    task automatic model_step(input int k, input logic rst, input logic tk,
                              input logic en, input int df);
        bit fire;
        if (rst) begin
            m_lfsr[k] = 0;
            m_left[k] = 0;
            m_cnt[k]  = 0;
            m_raw[k]  = 0;
            return;
        end
        fire = ((m_lfsr[k] % 512) + df) >= 512;
        if (!en) begin
            m_left[k] = 0;
        end else if (tk) begin
            if (m_left[k] > 0) begin
                m_left[k]--;
            end else if (fire) begin
                m_left[k] = m_hold[k] + m_gap[k];
                m_raw[k]++;
                if (m_cnt[k] < 255) m_cnt[k]++;
            end
        end
        if (tk) begin
            m_lfsr[k] = ((m_lfsr[k] * 2) % 1024)
                      + (1 - (((m_lfsr[k] / 512) % 2) ^ ((m_lfsr[k] / 64) % 2)));
        end
    endtask

    task automatic step(input logic rst, input logic tk, input logic en, input logic [8:0] df);
        logic tkb;
        tkb           = (cyc % 4 == 0);
        Reset         = rst;
        ia.tick       = tk;
        ia.enable     = en;
        ia.difficulty = df;
        ib.tick       = tkb;
        ib.enable     = en;
        ib.difficulty = df;
        @(posedge clock);
        model_step(0, rst, tk, en, int'(df));
        model_step(1, rst, tkb, en, int'(df));
        cyc++;
        #1;
        check("a_pressed", int'(ia.pressed), int'(m_left[0] > m_gap[0]));
        check("a_busy",    int'(ia.busy),    int'(m_left[0] > 0));
        check("a_count",   int'(ia.press_count), m_cnt[0]);
        check("b_pressed", int'(ib.pressed), int'(m_left[1] > m_gap[1]));
        check("b_busy",    int'(ib.busy),    int'(m_left[1] > 0));
        check("b_count",   int'(ib.press_count), m_cnt[1]);
    endtask

    initial begin
        int bound;

        // Reset state
        step(1'b1, 1'b0, 1'b0, 9'd0);
        step(1'b1, 1'b1, 1'b1, 9'd0);
        check("rst_pressed", int'(ia.pressed), 0);
        check("rst_count",   int'(ia.press_count), 0);

        // Difficulty 0 never fires
        for (int i = 0; i < 2000; i++) step(1'b0, 1'b1, 1'b1, 9'd0);
        check("d0_count", int'(ia.press_count), 0);
        check("d0_busy",  int'(ia.busy), 0);

        // Directed first presses from SEED=0 at difficulty 511, then an enable abort mid-HOLD
        step(1'b1, 1'b0, 1'b0, 9'd511);
        step(1'b0, 1'b1, 1'b1, 9'd511);
        check("dir_t1_pressed", int'(ia.pressed), 0);
        step(1'b0, 1'b1, 1'b1, 9'd511);
        check("dir_t2_pressed", int'(ia.pressed), 1);
        check("dir_t2_count",   int'(ia.press_count), 1);
        step(1'b0, 1'b1, 1'b1, 9'd511);
        check("dir_t3_pressed", int'(ia.pressed), 1);
        step(1'b0, 1'b1, 1'b1, 9'd511);
        check("dir_t4_pressed", int'(ia.pressed), 0);
        check("dir_t4_busy",    int'(ia.busy), 1);
        step(1'b0, 1'b1, 1'b1, 9'd511);
        check("dir_t5_busy",    int'(ia.busy), 0);
        step(1'b0, 1'b1, 1'b1, 9'd511);
        check("dir_t6_pressed", int'(ia.pressed), 1);
        check("dir_t6_count",   int'(ia.press_count), 2);
        step(1'b0, 1'b1, 1'b0, 9'd511);
        check("abort_pressed",  int'(ia.pressed), 0);
        check("abort_busy",     int'(ia.busy), 0);
        check("abort_count",    int'(ia.press_count), 2);
        step(1'b0, 1'b1, 1'b1, 9'd511);
        check("rearm_pressed",  int'(ia.pressed), 1);
        check("rearm_count",    int'(ia.press_count), 3);

        // Random enable, tick and difficulty
        for (int i = 0; i < 3000; i++) begin
            step(1'b0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) != 0),
                 9'($urandom));
        end

        // Saturation of press_count
        step(1'b1, 1'b0, 1'b0, 9'd511);
        bound = 0;
        while (m_raw[0] < 400 && bound < 6000) begin
            step(1'b0, 1'b1, 1'b1, 9'd511);
            bound++;
        end
        check("sat_reached", int'(m_raw[0] >= 400), 1);
        check("sat_count",   int'(ia.press_count), 255);

        // Reset while in GAP, then deterministic restart
        bound = 0;
        while (!(m_left[0] > 0 && m_left[0] <= m_gap[0]) && bound < 200) begin
            step(1'b0, 1'b1, 1'b1, 9'($urandom_range(300, 511)));
            bound++;
        end
        check("gap_reached", int'(m_left[0] > 0 && m_left[0] <= m_gap[0]), 1);
        step(1'b1, 1'b1, 1'b1, 9'd400);
        for (int i = 0; i < 300; i++) step(1'b0, 1'b1, 1'b1, 9'($urandom_range(200, 511)));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
